// File: rtl/sram_100_qsys_cpu_jtag_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug module: runs UIR/CDR/SDR/UDR/RTI
// sequences on a divided tck. Optional macro SCAN_MASTER_IR_SKIP_EN skips UIR when the IR is unchanged.
module sram_100_qsys_cpu_jtag_scan_master #(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DIV_W = $clog2(2 * TCK_DIV);
    localparam int BIT_W = $clog2(DR_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH  = DIV_W'(TCK_DIV);
    localparam logic [DIV_W-1:0] DIV_START = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI
    } state_t;

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [DR_WIDTH-1:0] data_reg, data_next;
    logic [DR_WIDTH-1:0] cap_reg, cap_next;
    logic [DR_WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic [1:0]          ir_in_reg, ir_in_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic                period_end;
    logic                skip_uir;
`ifdef SCAN_MASTER_IR_SKIP_EN
    logic                ir_known_reg, ir_known_next;
`endif

    assign period_end = (div_reg == DIV_LAST);

`ifdef SCAN_MASTER_IR_SKIP_EN
    assign skip_uir = ir_known_reg && (cmd_ir == ir_in_reg);
`else
    assign skip_uir = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            div_reg       <= '0;
            bit_reg       <= '0;
            data_reg      <= '0;
            cap_reg       <= '0;
            rsp_data_reg  <= '0;
            ir_in_reg     <= '0;
            rsp_valid_reg <= 1'b0;
`ifdef SCAN_MASTER_IR_SKIP_EN
            ir_known_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            bit_reg       <= bit_next;
            data_reg      <= data_next;
            cap_reg       <= cap_next;
            rsp_data_reg  <= rsp_data_next;
            ir_in_reg     <= ir_in_next;
            rsp_valid_reg <= rsp_valid_next;
`ifdef SCAN_MASTER_IR_SKIP_EN
            ir_known_reg  <= ir_known_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        bit_next       = bit_reg;
        data_next      = data_reg;
        cap_next       = cap_reg;
        rsp_data_next  = rsp_data_reg;
        ir_in_next     = ir_in_reg;
        rsp_valid_next = 1'b0;
`ifdef SCAN_MASTER_IR_SKIP_EN
        ir_known_next  = ir_known_reg;
`endif

        if (state_reg != S_IDLE) begin
            div_next = period_end ? '0 : div_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    // tck is already low in the acceptance cycle, so it serves as the
                    // first low cycle of the opening period; latency is whole periods.
                    div_next  = DIV_START;
                    bit_next  = '0;
                    data_next = cmd_data;
                    cap_next  = '0;
                    if (skip_uir) begin
                        state_next = S_CDR;
                    end else begin
                        state_next = S_UIR;
                        ir_in_next = cmd_ir;
`ifdef SCAN_MASTER_IR_SKIP_EN
                        ir_known_next = 1'b1;
`endif
                    end
                end
            end
            S_UIR: begin
                if (period_end) state_next = S_CDR;
            end
            S_CDR: begin
                if (period_end) state_next = S_SDR;
            end
            S_SDR: begin
                // Sample tdo just before tck rises, i.e. before the target shifts.
                if (div_reg == DIV_RISE) begin
                    cap_next = {vji_tdo, cap_reg[DR_WIDTH-1:1]};
                end
                if (period_end) begin
                    data_next = data_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        state_next = S_UDR;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            S_UDR: begin
                if (period_end) state_next = S_RTI;
            end
            S_RTI: begin
                if (period_end) begin
                    state_next     = S_IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = cap_reg;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign vji_tck   = (state_reg != S_IDLE) && (div_reg >= DIV_HIGH);
    assign vji_tdi   = (state_reg == S_SDR) && data_reg[0];
    assign vji_ir_in = ir_in_reg;
    assign vji_uir   = (state_reg == S_UIR);
    assign vji_cdr   = (state_reg == S_CDR);
    assign vji_sdr   = (state_reg == S_SDR);
    assign vji_udr   = (state_reg == S_UDR);
    assign vji_rti   = (state_reg == S_RTI) || (state_reg == S_IDLE);

endmodule

// File: tb/tb_sram_100_qsys_cpu_jtag_scan_master.sv
// Bench for the virtual-JTAG scan initiator: table-driven scans against a 38-bit
// target shift-register model, plus back-to-back, busy, mid-scan reset and IR-skip sequences.
module tb_sram_100_qsys_cpu_jtag_scan_master;

    localparam int DW = 38;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_ir = 2'b00;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [1:0]    vji_ir_in;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    sram_100_qsys_cpu_jtag_scan_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .vji_tck   (vji_tck),
        .vji_tdi   (vji_tdi),
        .vji_tdo   (vji_tdo),
        .vji_ir_in (vji_ir_in),
        .vji_uir   (vji_uir),
        .vji_cdr   (vji_cdr),
        .vji_sdr   (vji_sdr),
        .vji_udr   (vji_udr),
        .vji_rti   (vji_rti)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target data register: capture at CDR, shift right (tdi into MSB) in SDR.
    logic [DW-1:0] sr = '0;
    logic [DW-1:0] preload = '0;
    logic [DW-1:0] sr_at_udr = '0;
    int sdr_rises = 0;
    int uir_pulses = 0;
    assign vji_tdo = sr[0];

    always @(posedge vji_tck) begin
        if (vji_cdr) begin
            sr <= preload;
        end else if (vji_sdr) begin
            sr        <= {vji_tdi, sr[DW-1:1]};
            sdr_rises <= sdr_rises + 1;
        end
    end
    always @(posedge vji_uir) uir_pulses <= uir_pulses + 1;
    always @(posedge vji_udr) sr_at_udr <= sr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the rsp_valid negedge.
    task automatic run_scan(input logic [1:0] ir, input logic [DW-1:0] data,
                            input logic [DW-1:0] pre, input int pulse_at,
                            output int lat, output int rises, output int uirs,
                            output int busy_bad);
        int r0, u0, k;
        r0 = sdr_rises;
        u0 = uir_pulses;
        preload   = pre;
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        k = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = -1;
        busy_bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                lat = cyc - k;
                break;
            end
            if (cmd_ready) busy_bad++;
            cmd_valid = (pulse_at >= 0) && (sdr_rises - r0 == pulse_at);
            cmd_ir    = 2'b11;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rises = sdr_rises - r0;
        uirs  = uir_pulses - u0;
    endtask

    typedef struct {
        logic [1:0]    ir;
        logic [DW-1:0] data;
        logic [DW-1:0] pre;
        logic [DW-1:0] exp_rsp;
        logic [DW-1:0] exp_udr;
        int            exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int lat, lat2, rises, rises2, uirs, bad, k, cnt;
        logic rdy;

        vecs[0] = '{2'b01, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 38'h15_5555_5555, 38'h2A_AAAA_AAAA, 168};
        vecs[1] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 168};
        vecs[2] = '{2'b11, 38'h00_0000_0001, 38'h20_0000_0000, 38'h20_0000_0000, 38'h00_0000_0001, 168};
        vecs[3] = '{2'b01, 38'h12_3456_789A, 38'h0F_EDCB_A987, 38'h0F_EDCB_A987, 38'h12_3456_789A, 168};

        // Reset and idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, cmd_ready, rsp_valid},
              {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("reset_rsp_data", rsp_data, 0);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vji_tck !== 1'b0 || cmd_ready !== 1'b1 || vji_rti !== 1'b1) cnt++;
        end
        check("idle_static", cnt, 0);

        // Table-driven single scans
        foreach (vecs[v]) begin
            run_scan(vecs[v].ir, vecs[v].data, vecs[v].pre, -1, lat, rises, uirs, bad);
            $display("scan %0d ir=%b lat=%0d rsp=%h udr=%h", v, vecs[v].ir, lat, rsp_data, sr_at_udr);
            check("vec_latency", lat, vecs[v].exp_lat);
            check("vec_rsp_data", rsp_data, vecs[v].exp_rsp);
            check("vec_target_at_udr", sr_at_udr, vecs[v].exp_udr);
            check("vec_ir_in", vji_ir_in, vecs[v].ir);
            check("vec_sdr_rises", rises, 38);
            check("vec_uir_pulses", uirs, 1);
            check("vec_busy_ready", bad, 0);
        end

        // Back-to-back: cmd_valid held across both requests
        @(negedge clk);
        k = sdr_rises;
        preload   = 38'h00_0000_00FF;
        cmd_ir    = 2'b00;
        cmd_data  = 38'h01_2345_6789;
        cmd_valid = 1'b1;
        lat = cyc;
        @(negedge clk);
        cmd_ir   = 2'b10;
        cmd_data = 38'h3C_3C3C_3C3C;
        lat2 = -1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                lat2 = cyc - lat;
                break;
            end
            @(negedge clk);
        end
        rdy = cmd_ready;
        rises = sdr_rises - k;
        $display("b2b first lat=%0d rsp=%h ready=%b", lat2, rsp_data, rdy);
        check("b2b_first_latency", lat2, 168);
        check("b2b_first_rsp", rsp_data, 38'h00_0000_00FF);
        check("b2b_ready_with_rsp", rdy, 1);
        check("b2b_first_rises", rises, 38);
        preload = 38'h2B_CDEF_0123;
        k = sdr_rises;
        lat = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_accepted", cmd_ready, 0);
        lat2 = -1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                lat2 = cyc - lat;
                break;
            end
            @(negedge clk);
        end
        rises2 = sdr_rises - k;
        $display("b2b second lat=%0d rsp=%h ir=%b udr=%h", lat2, rsp_data, vji_ir_in, sr_at_udr);
        check("b2b_second_latency", lat2, 168);
        check("b2b_second_rsp", rsp_data, 38'h2B_CDEF_0123);
        check("b2b_second_ir", vji_ir_in, 2'b10);
        check("b2b_second_rises", rises2, 38);
        check("b2b_second_udr", sr_at_udr, 38'h3C_3C3C_3C3C);

        // Busy: cmd_valid pulsed during SDR must be ignored
        @(negedge clk);
        run_scan(2'b01, 38'h11_1111_1111, 38'h22_2222_2222, 5, lat, rises, uirs, bad);
        $display("busy scan lat=%0d rsp=%h ready_high_cycles=%0d", lat, rsp_data, bad);
        check("busy_latency", lat, 168);
        check("busy_ready_low", bad, 0);
        check("busy_rsp", rsp_data, 38'h22_2222_2222);
        k = sdr_rises;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) cnt++;
        end
        check("busy_no_extra_scan", cnt + (sdr_rises - k), 0);

        // Reset asserted mid-SDR
        k = sdr_rises;
        preload   = 38'h3F_0000_FFFF;
        cmd_ir    = 2'b11;
        cmd_data  = 38'h00_FFFF_0000;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 0;
        while (sdr_rises - k < 17 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("midreset_reached_bit17", sdr_rises - k, 17);
        reset_n = 1'b0;
        #1;
        $display("mid-scan reset outputs tck=%b sdr=%b rti=%b ready=%b ir=%b", vji_tck, vji_sdr, vji_rti, cmd_ready, vji_ir_in);
        check("midreset_outputs", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, cmd_ready, rsp_valid},
              {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("midreset_rsp_data", rsp_data, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("midreset_no_rsp", cnt, 0);
        run_scan(2'b10, 38'h05_A5A5_A5A5, 38'h1E_1E1E_1E1E, -1, lat, rises, uirs, bad);
        $display("post-reset scan lat=%0d rsp=%h", lat, rsp_data);
        check("postreset_latency", lat, 168);
        check("postreset_rsp", rsp_data, 38'h1E_1E1E_1E1E);
        check("postreset_udr", sr_at_udr, 38'h05_A5A5_A5A5);

        // Two scans with the same IR
        @(negedge clk);
        run_scan(2'b11, 38'h0A_0A0A_0A0A, 38'h33_3333_3333, -1, lat, rises, uirs, bad);
        $display("irskip first lat=%0d uir=%0d rsp=%h", lat, uirs, rsp_data);
        check("irskip_first_latency", lat, 168);
        check("irskip_first_uir", uirs, 1);
        check("irskip_first_rsp", rsp_data, 38'h33_3333_3333);
        @(negedge clk);
        run_scan(2'b11, 38'h15_1515_1515, 38'h0C_CCCC_CCCC, -1, lat, rises, uirs, bad);
        $display("irskip second lat=%0d uir=%0d rsp=%h", lat, uirs, rsp_data);
`ifdef SCAN_MASTER_IR_SKIP_EN
        check("irskip_second_latency", lat, 164);
        check("irskip_second_uir", uirs, 0);
`else
        check("irskip_second_latency", lat, 168);
        check("irskip_second_uir", uirs, 1);
`endif
        check("irskip_second_rsp", rsp_data, 38'h0C_CCCC_CCCC);
        check("irskip_second_udr", sr_at_udr, 38'h15_1515_1515);
        check("irskip_second_ir", vji_ir_in, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_100_qsys_cpu_jtag_scan_master.md
# sram_100_qsys_cpu_jtag_scan_master

Clock-domain scan initiator that drives the virtual-JTAG side of the Nios II debug module (`tck`, `tdi`, `ir_in`, and the `uir`/`cdr`/`sdr`/`udr`/`rti` state strobes) and captures `tdo`. It sits in the `clk` domain in place of the SLD virtual JTAG hub. It lets on-chip logic or a simulation bench issue complete IR+DR scans to the debug module's 38-bit shift register, without a physical JTAG cable.

## Interface
- `TCK_DIV`, 2, half-period of generated `vji_tck` in `clk` cycles; legal range 2..255.
- `DR_WIDTH`, 38, debug-module data-register length in bits.
- `clk`  input  1  system clock; all logic is clocked on its rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low. One clock; no other reset.
- `cmd_valid`  input  1  scan request.
- `cmd_ready`  output  1  block idle and able to accept a request.
- `cmd_ir`  input  2  instruction value for `vji_ir_in`.
- `cmd_data`  input  DR_WIDTH  data shifted in, LSB first.
- `rsp_valid`  output  1  one-cycle pulse when the scan is complete.
- `rsp_data`  output  DR_WIDTH  data captured from `vji_tdo`, LSB first; held until the next `rsp_valid`.
- `vji_tck`  output  1  generated test clock.
- `vji_tdi`  output  1  serial data to the target.
- `vji_tdo`  input  1  serial data from the target.
- `vji_ir_in`  output  2  current instruction.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  output  1 each  virtual state strobes.

## Operation
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI. Every state other than IDLE lasts an integer number of tck periods.
- IDLE:
  - `cmd_ready`=1 and `vji_rti`=1; `vji_tck` is held at 0.
  - A request is accepted when `cmd_valid`&&`cmd_ready`. On acceptance, the block latches `cmd_ir` and `cmd_data` and moves to UIR.
- UIR: lasts 1 period. `vji_uir`=1. `vji_ir_in` takes the latched `cmd_ir` at the start of this state and holds it until the next UIR.
- CDR: lasts 1 period. `vji_cdr`=1. The target captures its register on the tck rising edge within this state.
- SDR: lasts `DR_WIDTH` periods; `vji_sdr`=1. In period i (i = 0..DR_WIDTH-1):
  - `vji_tdi` = `cmd_data[i]`.
  - `rsp_data[i]` is loaded from `vji_tdo`, sampled in the `clk` cycle that drives `vji_tck` 0→1.
  - The bit counter counts from 0 to DR_WIDTH-1. Its width is `$clog2(DR_WIDTH)`.
- UDR: lasts 1 period. `vji_udr`=1. This hold time of at least 4 `clk` cycles satisfies the debug module's 2-flop `udr` synchronizer.
- RTI: lasts 1 period. `vji_rti`=1. The FSM then returns to IDLE.
- Exactly one strobe is high in every non-IDLE state. `vji_tdi`=0 outside SDR.
- `rsp_valid` pulses in the first IDLE cycle after RTI, with `cmd_ready`=1 in the same cycle. A request presented in that cycle is accepted, so back-to-back scans are legal.
- `cmd_valid` outside IDLE is ignored. It is not queued.

## Timing
- One tck period is 2·TCK_DIV `clk` cycles: `vji_tck`=0 for the first TCK_DIV cycles and 1 for the last TCK_DIV cycles.
- All strobes, `vji_tdi` and `vji_ir_in` change only on the `clk` edge that starts a period, while `vji_tck` is low.
- Scan latency, from the acceptance cycle to the `rsp_valid` cycle, is (DR_WIDTH+4)·2·TCK_DIV `clk` cycles. With the defaults this is 168.
- Reset values:
  - `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0.
  - `vji_uir`/`vji_cdr`/`vji_sdr`/`vji_udr`=0; `vji_rti`=1.
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0.
  - FSM in IDLE.
- Reset asserted mid-scan forces every output to its reset value immediately. The scan in progress is discarded and no `rsp_valid` is produced.

## Configuration
- `SCAN_MASTER_IR_SKIP_EN`
  - Defined:
    - The block keeps the last IR value it loaded, plus a valid flag that is cleared by reset.
    - If the flag is set and `cmd_ir` equals the stored value, the scan goes from IDLE directly to CDR. No `vji_uir` pulse is issued and latency drops by 2·TCK_DIV cycles.
  - Undefined: every scan passes through UIR.

## Test plan
- **Reset and idle.** Hold `reset_n`=0 for 5 cycles, then release. Required: all outputs at their reset values, `cmd_ready`=1, `vji_tck` static at 0 for 20 cycles.
- **Single scan against a bench shift-register model.** Model preloaded at CDR with 38'h15_5555_5555; request `cmd_ir`=2'b01, `cmd_data`=38'h2A_AAAA_AAAA; TCK_DIV=2. Required:
  - `rsp_valid` exactly 168 cycles after acceptance.
  - `rsp_data`=38'h15_5555_5555.
  - Model register equals 38'h2A_AAAA_AAAA at UDR.
  - `vji_ir_in`=2'b01.
- **Back-to-back scans.** Hold `cmd_valid` high for two requests (ir 2'b00 then 2'b10). Required: the second request is accepted in the same cycle as the first `rsp_valid`, and there are exactly 38 SDR rising edges per scan.
- **Busy behaviour.** Pulse `cmd_valid` during SDR. Required: ignored, with no extra scan and `cmd_ready`=0 throughout the scan.
- **Reset mid-scan.** Assert `reset_n`=0 at SDR bit 17. Required: outputs reach reset values in the same cycle, no `rsp_valid` appears, and the next request completes normally.
- **IR skip (macro defined).** Send two scans with `cmd_ir`=2'b11. Required: the first scan has one `vji_uir` pulse and 168-cycle latency; the second has no `vji_uir` and 164-cycle latency. With the macro undefined, both scans take 168 cycles.
